// File: rtl/bomb_countdown.sv
// Bomb-defuse countdown core: ms tick accumulation, BCD MM:SS decrement,
// wrong-wire penalties, pause/defuse/clear handling and explosion at 00:00.
module bomb_countdown #(
  parameter int unsigned MS_PER_SEC  = 1000,
  parameter int unsigned PENALTY_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       load,
  input  logic [3:0] preset_mt,
  input  logic [3:0] preset_mo,
  input  logic [3:0] preset_st,
  input  logic [3:0] preset_so,
  input  logic       start,
  input  logic       pause,
  input  logic       penalty,
  input  logic       defuse,
  input  logic       clr,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       exploded,
  output logic       defused,
  output logic       sec_pulse
);

  localparam int unsigned MS_W   = $clog2(MS_PER_SEC);
  localparam int unsigned PEND_W = 8;
  localparam logic [MS_W-1:0]   MS_LAST  = MS_W'(MS_PER_SEC - 1);
  localparam logic [PEND_W:0]   PEND_MAX = (PEND_W+1)'(255);
  localparam logic [PEND_W:0]   PEN_ADD  = (PEND_W+1)'(PENALTY_SEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         tm_q, tm_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [PEND_W:0]     pend_sum;
  logic                pulse_d;
  logic                tick_dec;
  logic                pend_dec;
  logic                add_pen;

  // One-second BCD decrement with borrow chain; holds at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t != 16'h0000) begin
      if (so != 4'd0) so = so - 4'd1;
      else begin
        so = 4'd9;
        if (st != 4'd0) st = st - 4'd1;
        else begin
          st = 4'd5;
          if (mo != 4'd0) mo = mo - 4'd1;
          else begin
            mo = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] clamp_preset(input logic [3:0] mt, input logic [3:0] mo,
                                               input logic [3:0] st, input logic [3:0] so);
    return {(mt > 4'd9) ? 4'd9 : mt,
            (mo > 4'd9) ? 4'd9 : mo,
            (st > 4'd5) ? 4'd5 : st,
            (so > 4'd9) ? 4'd9 : so};
  endfunction

  // Next-state, digit, ms-counter and pending-penalty logic.
  always_comb begin
    state_d  = state_q;
    tm_d     = tm_q;
    ms_d     = ms_q;
    pend_d   = pend_q;
    pulse_d  = 1'b0;
    tick_dec = 1'b0;
    pend_dec = 1'b0;
    add_pen  = 1'b0;
    pend_sum = '0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          tm_d = clamp_preset(preset_mt, preset_mo, preset_st, preset_so);
        end else if (start && (tm_q != 16'h0000)) begin
          state_d = S_RUN;
          ms_d    = '0;
        end
      end
      S_RUN: begin
        add_pen = penalty;
        if (defuse) begin
          state_d = S_DEFUSED;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else begin
          if (ms_tick) begin
            if (ms_q == MS_LAST) begin
              ms_d     = '0;
              tick_dec = 1'b1;
            end else begin
              ms_d = ms_q + MS_W'(1);
            end
          end
          pend_dec = !tick_dec && (pend_q != '0);
        end
      end
      S_PAUSED: begin
        add_pen = penalty;
        if (defuse) state_d = S_DEFUSED;
        else if (start) state_d = S_RUN;
      end
      S_DEFUSED, S_EXPLODED: begin
        if (clr) begin
          state_d = S_IDLE;
          tm_d    = 16'h0000;
          ms_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pend_sum = {1'b0, pend_q} + (add_pen ? PEN_ADD : '0) - (PEND_W+1)'(pend_dec);
    pend_d   = (pend_sum > PEND_MAX) ? '1 : pend_sum[PEND_W-1:0];

    if (tick_dec || pend_dec) begin
      tm_d    = bcd_dec(tm_q);
      pulse_d = tick_dec;
      if (tm_d == 16'h0000) begin
        state_d = S_EXPLODED;
        ms_d    = '0;
      end
    end

    // Pending seconds only survive while the game is live.
    if ((state_d != S_RUN) && (state_d != S_PAUSED)) pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tm_q      <= 16'h0000;
      ms_q      <= '0;
      pend_q    <= '0;
      running   <= 1'b0;
      exploded  <= 1'b0;
      defused   <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      tm_q      <= tm_d;
      ms_q      <= ms_d;
      pend_q    <= pend_d;
      running   <= (state_d == S_RUN);
      exploded  <= (state_d == S_EXPLODED);
      defused   <= (state_d == S_DEFUSED);
      sec_pulse <= pulse_d;
    end
  end

  assign min_tens = tm_q[15:12];
  assign min_ones = tm_q[11:8];
  assign sec_tens = tm_q[7:4];
  assign sec_ones = tm_q[3:0];

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown: stimulus queues expected snapshots, a
// negedge monitor compares them against the DUT on the tagged cycle.
module tb_bomb_countdown;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ms_tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic       penalty = 1'b0, defuse = 1'b0, clr = 1'b0;
  logic [3:0] preset_mt = '0, preset_mo = '0, preset_st = '0, preset_so = '0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, exploded, defused, sec_pulse;

  bomb_countdown #(.MS_PER_SEC(4), .PENALTY_SEC(10)) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .load(load),
    .preset_mt(preset_mt), .preset_mo(preset_mo), .preset_st(preset_st), .preset_so(preset_so),
    .start(start), .pause(pause), .penalty(penalty), .defuse(defuse), .clr(clr),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .exploded(exploded), .defused(defused), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  // flags = {running, exploded, defused, sec_pulse}
  typedef struct {
    int          cyc;
    string       nm;
    logic [15:0] tm;
    logic [3:0]  flags;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle tag has come due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc);
      end else if ({min_tens, min_ones, sec_tens, sec_ones} === e.tm &&
                   {running, exploded, defused, sec_pulse} === e.flags) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got time %h flags %b, expected time %h flags %b", e.nm,
                 {min_tens, min_ones, sec_tens, sec_ones},
                 {running, exploded, defused, sec_pulse}, e.tm, e.flags);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [15:0] tm, input logic [3:0] flags);
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.tm = tm; x.flags = flags;
    q.push_back(x);
  endtask

  // Present the currently driven inputs for one rising edge, then release pulses.
  task automatic cycle();
    @(posedge clk);
    #1;
    ms_tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    penalty = 1'b0; defuse = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ms_tick = 1'b1;
      cycle();
    end
  endtask

  task automatic load_t(input logic [3:0] mt, input logic [3:0] mo,
                        input logic [3:0] st, input logic [3:0] so);
    preset_mt = mt; preset_mo = mo; preset_st = st; preset_so = so;
    load = 1'b1;
    cycle();
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
  endtask

  task automatic defuse_clr();
    defuse = 1'b1;
    cycle();
    clr = 1'b1;
    cycle();
  endtask

  initial begin
    cycle();
    expect_now("reset_state", 16'h0000, 4'b0000);
    rst = 1'b1;
    cycle();

    // Borrow across seconds and minutes
    load_t(4'd0, 4'd1, 4'd0, 4'd0);
    expect_now("load_0100", 16'h0100, 4'b0000);
    do_start();
    expect_now("start_0100", 16'h0100, 4'b1000);
    ticks(3);
    expect_now("pre_wrap", 16'h0100, 4'b1000);
    ticks(1);
    expect_now("borrow_0059", 16'h0059, 4'b1001);
    cycle();
    expect_now("pulse_one_cycle", 16'h0059, 4'b1000);
    defuse = 1'b1;
    cycle();
    expect_now("defuse_run", 16'h0059, 4'b0010);
    clr = 1'b1;
    cycle();
    expect_now("clr_defused", 16'h0000, 4'b0000);
    load_t(4'd1, 4'd0, 4'd0, 4'd0);
    do_start();
    ticks(4);
    expect_now("borrow_0959", 16'h0959, 4'b1001);
    defuse_clr();

    // Explosion and frozen terminal state
    load_t(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    ticks(4);
    expect_now("explode_0001", 16'h0001, 4'b1001);
    ticks(4);
    expect_now("explode_hit", 16'h0000, 4'b0101);
    ms_tick = 1'b1; start = 1'b1; defuse = 1'b1;
    cycle();
    expect_now("explode_hold", 16'h0000, 4'b0100);
    ticks(2);
    expect_now("explode_hold2", 16'h0000, 4'b0100);
    clr = 1'b1;
    cycle();
    expect_now("clr_exploded", 16'h0000, 4'b0000);
    do_start();
    expect_now("start_zero_ignored", 16'h0000, 4'b0000);

    // Penalty drain, one second per cycle
    load_t(4'd0, 4'd0, 4'd1, 4'd5);
    do_start();
    penalty = 1'b1;
    cycle();
    expect_now("penalty_pulse", 16'h0015, 4'b1000);
    cycle();
    expect_now("penalty_1", 16'h0014, 4'b1000);
    idle(8);
    expect_now("penalty_9", 16'h0006, 4'b1000);
    cycle();
    expect_now("penalty_10", 16'h0005, 4'b1000);
    cycle();
    expect_now("penalty_done", 16'h0005, 4'b1000);
    penalty = 1'b1;
    cycle();
    idle(4);
    expect_now("penalty2_4", 16'h0001, 4'b1000);
    cycle();
    expect_now("penalty2_explode", 16'h0000, 4'b0100);
    idle(3);
    expect_now("penalty2_hold", 16'h0000, 4'b0100);
    clr = 1'b1;
    cycle();

    // Penalty draining while the ms counter wraps
    load_t(4'd0, 4'd0, 4'd2, 4'd0);
    do_start();
    ticks(2);
    penalty = 1'b1;
    cycle();
    expect_now("wrap_pen_pulse", 16'h0020, 4'b1000);
    ticks(1);
    expect_now("wrap_pen_dec", 16'h0019, 4'b1000);
    ticks(1);
    expect_now("wrap_tick_dec", 16'h0018, 4'b1001);
    cycle();
    expect_now("wrap_pen_resume", 16'h0017, 4'b1000);
    idle(8);
    expect_now("wrap_pen_end", 16'h0009, 4'b1000);
    cycle();
    expect_now("wrap_pen_empty", 16'h0009, 4'b1000);
    defuse_clr();

    // Pause / resume keeps the ms count
    load_t(4'd0, 4'd0, 4'd1, 4'd0);
    do_start();
    ticks(3);
    pause = 1'b1;
    cycle();
    expect_now("paused", 16'h0010, 4'b0000);
    ticks(10);
    expect_now("paused_ticks", 16'h0010, 4'b0000);
    do_start();
    expect_now("resumed", 16'h0010, 4'b1000);
    ticks(1);
    expect_now("resume_tick", 16'h0009, 4'b1001);

    // Defuse beats a wrapping tick
    ticks(3);
    ms_tick = 1'b1; defuse = 1'b1;
    cycle();
    expect_now("defuse_on_wrap", 16'h0009, 4'b0010);
    clr = 1'b1;
    cycle();

    // Clamping and load-over-start
    load_t(4'd0, 4'd1, 4'd7, 4'd12);
    expect_now("clamp_0159", 16'h0159, 4'b0000);
    load_t(4'd12, 4'd15, 4'd9, 4'd10);
    expect_now("clamp_9959", 16'h9959, 4'b0000);
    preset_mt = 4'd0; preset_mo = 4'd0; preset_st = 4'd3; preset_so = 4'd0;
    load = 1'b1; start = 1'b1;
    cycle();
    expect_now("load_beats_start", 16'h0030, 4'b0000);

    // Asynchronous reset in the middle of a penalty drain
    do_start();
    penalty = 1'b1;
    cycle();
    cycle();
    expect_now("pre_reset", 16'h0029, 4'b1000);
    cycle();
    rst = 1'b0;
    expect_now("async_reset", 16'h0000, 4'b0000);
    cycle();
    expect_now("reset_held", 16'h0000, 4'b0000);
    rst = 1'b1;
    cycle();
    do_start();
    expect_now("post_reset_idle", 16'h0000, 4'b0000);

    idle(3);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never compared, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bomb_countdown.md
# bomb_countdown

Countdown core for the bomb-defuse timer. Consumes the one-cycle 1 ms tick from the millisecond tick generator, accumulates MS_PER_SEC ticks into a second, and decrements a four-digit BCD MM:SS value. It also applies wrong-wire time penalties, handles pause, defuse and clear, and flags explosion at 00:00. Outputs drive the seven-segment display driver and the game-status logic.

## Interface
- MS_PER_SEC, 1000, ms ticks per second; legal range 2..1023; ms counter width is $clog2(MS_PER_SEC).
- PENALTY_SEC, 10, seconds removed per penalty pulse; legal range 1..99.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset: one clock, asynchronous, active-low.
- ms_tick  in  1  one-cycle pulse from the ms tick generator.
- load  in  1  capture preset digits; honoured in IDLE only.
- preset_mt, preset_mo, preset_st, preset_so  in  4 each  preset minute tens/ones and second tens/ones, BCD.
- start  in  1  IDLE→RUN or PAUSED→RUN.
- pause  in  1  RUN→PAUSED.
- penalty  in  1  one-cycle pulse; adds PENALTY_SEC to the pending-penalty count.
- defuse  in  1  RUN/PAUSED→DEFUSED.
- clr  in  1  DEFUSED/EXPLODED→IDLE.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current time, BCD, registered.
- running  out  1  state == RUN.
- exploded  out  1  state == EXPLODED.
- defused  out  1  state == DEFUSED.
- sec_pulse  out  1  one-cycle pulse on each tick-driven second decrement.

## Operation
- States: IDLE, RUN, PAUSED, DEFUSED, EXPLODED.
- Reset:
  - state IDLE; all digits 0; ms counter and 8-bit pending-penalty counter 0.
  - All outputs 0.
- IDLE:
  - load=1 captures the preset digits. Clamp: any ones digit >9 becomes 9; preset_st >5 becomes 5; preset_mt >9 becomes 9.
  - start=1 with time ≠ 00:00 goes to RUN and clears the ms counter. start with 00:00 is ignored.
  - If load and start are both high, load wins; start is ignored that cycle.
  - ms_tick, penalty and defuse are ignored.
- RUN, priority per cycle (highest first):
  1. defuse → DEFUSED; no decrement that cycle; pending cleared.
  2. pause → PAUSED; ms counter retained; no decrement that cycle.
  3. ms_tick:
     - ms counter == MS_PER_SEC-1: counter → 0; one-second decrement; sec_pulse=1.
     - Otherwise: counter +1.
  4. If no tick-driven decrement this cycle and pending > 0: one-second decrement; pending −1.
- At most one one-second decrement per cycle.
- penalty pulse in RUN or PAUSED: pending += PENALTY_SEC, saturating at 255. This applies even in a cycle where pending is also decremented: net result is pending + PENALTY_SEC − 1.
- Penalty decrements are applied only in RUN.
- BCD decrement with borrow chain:
  - sec_ones 0→9, borrow to sec_tens.
  - sec_tens 0→5, borrow to min_ones.
  - min_ones 0→9, borrow to min_tens.
  - Time never goes below 00:00.
- When a decrement produces 00:00: state → EXPLODED on the same edge; pending cleared; ms counter cleared.
- PAUSED:
  - ms_tick ignored.
  - start → RUN; the ms counter resumes from its held value.
  - defuse → DEFUSED; defuse has priority over start.
- DEFUSED and EXPLODED: all inputs ignored except clr. Digits frozen.
- clr → IDLE; digits 00:00; ms counter and pending cleared.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- A tick sampled at edge N shows its digit update and sec_pulse after edge N.
- exploded rises on the same edge as the digits reach 00:00; running falls on that same edge.
- After start, the first decrement occurs on the MS_PER_SEC-th accepted tick.
- Penalty of P seconds with no concurrent ticks completes in P consecutive cycles.
- Asynchronous rst assertion immediately forces the reset values, regardless of clk, including mid-run or mid-penalty. Deassertion takes effect at the next rising edge.

## Test plan
Benches run with MS_PER_SEC=4 and PENALTY_SEC=10.
- Reset: assert rst mid-RUN between edges → digits 00:00, running/exploded/defused/sec_pulse 0 immediately, before the next edge.
- Borrow: load 01:00, start, 4 ticks → 00:59, one sec_pulse. Load 10:00 and run 4 ticks → 09:59.
- Explode: load 00:02, start, 8 ticks → 00:00 and exploded=1 on the same edge. Further ticks, start and defuse → no change. clr → IDLE.
- Penalty:
  - Load 00:15, start, one penalty pulse, no ticks → 00:05 after 10 cycles.
  - Second penalty → 00:00 after 5 cycles, exploded=1, pending 0.
  - Penalty coincident with a ms-counter wrap → tick decrement first, penalty decrement resumes the next cycle.
- Pause/resume: load 00:10, start, 3 ticks, pause, 10 ticks ignored, start, 1 tick → 00:09.
- Defuse: defuse asserted in the same cycle as the 4th tick → defused=1, digits stay at the pre-tick value, sec_pulse 0.
- Clamp: load preset_st=7, preset_so=12 → digits read x:59.
